// File: rtl/heart_key_stepper.sv
// Turns UART bytes into frame-locked one-cycle W/A/S/D step pulses, with a per-direction hold timeout.
// Optional feature: define HEART_KEY_IMMEDIATE_STEP_EN for an extra step on a fresh key press.
module heart_key_stepper #(
    parameter int HOLD_FRAMES = 8,
    parameter int STEP_DIV    = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    input  logic       i_ani_stb,
    output logic       o_w_key,
    output logic       o_a_key,
    output logic       o_s_key,
    output logic       o_d_key,
    output logic [3:0] o_held
);

    localparam logic [7:0] HOLD_INIT = 8'(HOLD_FRAMES);
    localparam logic [7:0] DIV_LAST  = 8'(STEP_DIV - 1);

    // Returns {release_all, load[D,S,A,W]}; unknown bytes decode to nothing.
    function automatic logic [4:0] decode_byte(input logic [7:0] b);
        logic [4:0] r;
        case (b)
            8'h77, 8'h57: r = 5'b0_0001;
            8'h61, 8'h41: r = 5'b0_0010;
            8'h73, 8'h53: r = 5'b0_0100;
            8'h64, 8'h44: r = 5'b0_1000;
            8'h20:        r = 5'b1_0000;
            default:      r = 5'b0_0000;
        endcase
        return r;
    endfunction

    logic [7:0] cnt_r      [4];
    logic [7:0] cnt_next_s [4];
    logic [7:0] div_r;
    logic [7:0] div_next_s;
    logic [3:0] held_r;
    logic [3:0] held_next_s;
    logic [3:0] key_r;
    logic [3:0] key_next_s;
    logic [3:0] load_s;
    logic [3:0] clear_s;
    logic       release_s;
    logic       qual_s;

    // Byte decode; a direction load also clears its opposite (W<->S, A<->D).
    always_comb begin
        load_s    = 4'b0000;
        release_s = 1'b0;
        if (i_rx_valid) begin
            {release_s, load_s} = decode_byte(i_rx_data);
        end else begin
            {release_s, load_s} = 5'b0_0000;
        end
        clear_s = {4{release_s}} | {load_s[1:0], load_s[3:2]};
    end

    // Hold counters: clear beats load beats strobe decrement.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            cnt_next_s[k] = cnt_r[k];
            if (clear_s[k]) begin
                cnt_next_s[k] = 8'd0;
            end else if (load_s[k]) begin
                cnt_next_s[k] = HOLD_INIT;
            end else if (i_ani_stb && (cnt_r[k] != 8'd0)) begin
                cnt_next_s[k] = cnt_r[k] - 8'd1;
            end else begin
                cnt_next_s[k] = cnt_r[k];
            end
            held_next_s[k] = (cnt_next_s[k] != 8'd0);
        end
    end

    // Step divider and pulse decision, using the held state registered before this cycle.
    always_comb begin
        div_next_s = div_r;
        qual_s     = i_ani_stb && (div_r == 8'd0);
        if (i_ani_stb) begin
            div_next_s = (div_r >= DIV_LAST) ? 8'd0 : (div_r + 8'd1);
        end else begin
            div_next_s = div_r;
        end
        key_next_s = qual_s ? held_r : 4'b0000;
`ifdef HEART_KEY_IMMEDIATE_STEP_EN
        // A fresh press merges with any strobe pulse into one pulse.
        key_next_s = key_next_s | (load_s & ~held_r);
`endif
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < 4; k++) begin
                cnt_r[k] <= 8'd0;
            end
            div_r  <= 8'd0;
            held_r <= 4'b0000;
            key_r  <= 4'b0000;
        end else begin
            for (int k = 0; k < 4; k++) begin
                cnt_r[k] <= cnt_next_s[k];
            end
            div_r  <= div_next_s;
            held_r <= held_next_s;
            key_r  <= key_next_s;
        end
    end

    assign o_held  = held_r;
    assign o_w_key = key_r[0];
    assign o_a_key = key_r[1];
    assign o_s_key = key_r[2];
    assign o_d_key = key_r[3];

endmodule

// File: tb/tb_heart_key_stepper.sv
// Scoreboard bench: unit 0 (HOLD_FRAMES=3, STEP_DIV=1) and unit 1 (HOLD_FRAMES=9, STEP_DIV=3).
module tb_heart_key_stepper;

`ifdef HEART_KEY_IMMEDIATE_STEP_EN
    localparam bit IMM = 1'b1;
`else
    localparam bit IMM = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] keys;
    } ev_t;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [7:0] rx_data0 = 8'h00, rx_data1 = 8'h00;
    logic       rx_valid0 = 1'b0, rx_valid1 = 1'b0;
    logic       stb0 = 1'b0, stb1 = 1'b0;
    logic       w0, a0, s0, d0, w1, a1, s1, d1;
    logic [3:0] held0, held1;

    int  cyc = 0;
    int  n_total = 0;
    int  n_pass = 0;
    ev_t q0[$];
    ev_t q1[$];

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    heart_key_stepper #(.HOLD_FRAMES(3), .STEP_DIV(1)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rx_data(rx_data0), .i_rx_valid(rx_valid0),
        .i_ani_stb(stb0), .o_w_key(w0), .o_a_key(a0), .o_s_key(s0), .o_d_key(d0), .o_held(held0)
    );

    heart_key_stepper #(.HOLD_FRAMES(9), .STEP_DIV(3)) dut_div (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rx_data(rx_data1), .i_rx_valid(rx_valid1),
        .i_ani_stb(stb1), .o_w_key(w1), .o_a_key(a1), .o_s_key(s1), .o_d_key(d1), .o_held(held1)
    );

    // Monitor: every observed pulse must match the next expected event for that unit.
    task automatic check_pulse(input int u, input logic [3:0] keys);
        ev_t ev;
        int  sz;
        sz = (u == 0) ? q0.size() : q1.size();
        n_total++;
        if (sz == 0) begin
            $display("FAIL unexpected_pulse unit%0d cyc=%0d got=%b expected none", u, cyc, keys);
        end else begin
            if (u == 0) ev = q0.pop_front();
            else        ev = q1.pop_front();
            if (ev.cyc == cyc && ev.keys == keys) begin
                n_pass++;
            end else begin
                $display("FAIL pulse unit%0d got cyc=%0d keys=%b expected cyc=%0d keys=%b",
                         u, cyc, keys, ev.cyc, ev.keys);
            end
        end
    endtask

    always @(negedge i_clk) begin
        if ({d0, s0, a0, w0} != 4'b0000) check_pulse(0, {d0, s0, a0, w0});
        if ({d1, s1, a1, w1} != 4'b0000) check_pulse(1, {d1, s1, a1, w1});
    end

    task automatic step(input int u, input logic [7:0] d, input logic v, input logic s);
        if (u == 0) begin
            rx_data0 = d; rx_valid0 = v; stb0 = s;
        end else begin
            rx_data1 = d; rx_valid1 = v; stb1 = s;
        end
        @(posedge i_clk);
        #1;
        rx_data0 = 8'h00; rx_valid0 = 1'b0; stb0 = 1'b0;
        rx_data1 = 8'h00; rx_valid1 = 1'b0; stb1 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 8'h00, 1'b0, 1'b0);
    endtask

    // Expect a pulse right after the edge just taken by step().
    task automatic expect_pulse(input int u, input logic [3:0] keys);
        ev_t ev;
        ev.cyc  = cyc;
        ev.keys = keys;
        if (u == 0) q0.push_back(ev);
        else        q1.push_back(ev);
    endtask

    task automatic press(input int u, input logic [7:0] d, input logic [3:0] newly);
        step(u, d, 1'b1, 1'b0);
        if (IMM && newly != 4'b0000) expect_pulse(u, newly);
    endtask

    task automatic check_held(input int u, input logic [3:0] exp, input string name);
        logic [3:0] got;
        got = (u == 0) ? held0 : held1;
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL held_%s unit%0d got=%b expected=%b", name, u, got, exp);
    endtask

    initial begin
        // Reset with traffic that must be discarded.
        i_rst_n = 1'b0;
        repeat (4) begin
            step(0, 8'h77, 1'b1, 1'b1);
            step(1, 8'h73, 1'b1, 1'b1);
        end
        check_held(0, 4'b0000, "reset");
        check_held(1, 4'b0000, "reset");
        i_rst_n = 1'b1;
        repeat (20) begin
            step(0, 8'h00, 1'b0, 1'b1);
            step(0, 8'h00, 1'b0, 1'b0);
        end
        check_held(0, 4'b0000, "idle");

        // Single press, three pulses then release.
        press(0, 8'h77, 4'b0001);
        check_held(0, 4'b0001, "press_w");
        for (int i = 0; i < 5; i++) begin
            step(0, 8'h00, 1'b0, 1'b1);
            if (i < 3) expect_pulse(0, 4'b0001);
            check_held(0, (i < 2) ? 4'b0001 : 4'b0000, "w_decay");
            idle(9);
        end

        // Opposite cancel A -> D.
        press(0, 8'h61, 4'b0010);
        check_held(0, 4'b0010, "press_a");
        repeat (2) begin
            step(0, 8'h00, 1'b0, 1'b1);
            expect_pulse(0, 4'b0010);
            idle(3);
        end
        press(0, 8'h44, 4'b1000);
        check_held(0, 4'b1000, "cancel_d");
        for (int i = 0; i < 4; i++) begin
            step(0, 8'h00, 1'b0, 1'b1);
            if (i < 3) expect_pulse(0, 4'b1000);
            idle(2);
        end
        check_held(0, 4'b0000, "d_done");

        // Byte colliding with a strobe while W idle: counter loads to full.
        step(0, 8'h77, 1'b1, 1'b1);
        if (IMM) expect_pulse(0, 4'b0001);
        check_held(0, 4'b0001, "collide_w");
        for (int i = 0; i < 3; i++) begin
            idle(1);
            step(0, 8'h00, 1'b0, 1'b1);
            expect_pulse(0, 4'b0001);
        end
        check_held(0, 4'b0000, "collide_done");

        // Cancelled key still pulses on the colliding strobe.
        press(0, 8'h77, 4'b0001);
        idle(1);
        step(0, 8'h73, 1'b1, 1'b1);
        expect_pulse(0, IMM ? 4'b0101 : 4'b0001);
        check_held(0, 4'b0100, "cancel_collide");
        press(0, 8'h20, 4'b0000);
        check_held(0, 4'b0000, "space1");

        // Space release, re-press and garbage bytes.
        press(0, 8'h77, 4'b0001);
        press(0, 8'h64, 4'b1000);
        check_held(0, 4'b1001, "w_and_d");
        press(0, 8'h57, 4'b0000);
        check_held(0, 4'b1001, "repress_w");
        press(0, 8'h20, 4'b0000);
        check_held(0, 4'b0000, "space2");
        press(0, 8'h7A, 4'b0000);
        check_held(0, 4'b0000, "garbage_idle");
        press(0, 8'h41, 4'b0010);
        press(0, 8'h7A, 4'b0000);
        check_held(0, 4'b0010, "garbage_held");
        step(0, 8'h00, 1'b0, 1'b1);
        expect_pulse(0, 4'b0010);
        check_held(0, 4'b0010, "a_after_garbage");
        press(0, 8'h20, 4'b0000);
        check_held(0, 4'b0000, "space3");

        // Reset mid-hold drops state.
        press(0, 8'h53, 4'b0100);
        i_rst_n = 1'b0;
        idle(1);
        i_rst_n = 1'b1;
        check_held(0, 4'b0000, "midhold_reset");
        repeat (3) begin
            step(0, 8'h00, 1'b0, 1'b1);
            idle(1);
        end
        check_held(0, 4'b0000, "after_reset");

        // Divider: S held by re-sends, pulses on strobes 1, 4, 7 and 10.
        press(1, 8'h73, 4'b0100);
        for (int i = 0; i < 10; i++) begin
            step(1, 8'h00, 1'b0, 1'b1);
            if (i % 3 == 0) expect_pulse(1, 4'b0100);
            step(1, 8'h73, 1'b1, 1'b0);
        end
        check_held(1, 4'b0100, "div_held");
        press(1, 8'h20, 4'b0000);
        check_held(1, 4'b0000, "div_space");

        idle(4);
        while (q0.size() > 0) begin
            n_total++;
            $display("FAIL missing_pulse unit0 got none expected cyc=%0d keys=%b", q0[0].cyc, q0[0].keys);
            void'(q0.pop_front());
        end
        while (q1.size() > 0) begin
            n_total++;
            $display("FAIL missing_pulse unit1 got none expected cyc=%0d keys=%b", q1[0].cyc, q1[0].keys);
            void'(q1.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
